// File: rtl/fifo_pkg.sv
// Shared types for the async FIFO read-side logic.
// The occupancy state type lives here so that checkers can reuse it.
package fifo_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // True when the skid buffer can accept another word this cycle.
  function automatic logic occ_has_room(input occ_state_e st);
    return (st != OCC_TWO);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: occupancy FSM, head and skid registers, push/pop handling.
// The head register drives the stream data; the skid register holds the next word.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [DSIZE-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [DSIZE-1:0] o_data,
  output occ_state_e       o_state
);

  occ_state_e       r_state;
  occ_state_e       w_state_nxt;
  logic             r_valid;
  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_skid;
  logic [DSIZE-1:0] w_head_nxt;
  logic [DSIZE-1:0] w_skid_nxt;
  logic             w_pop;

  assign w_pop = r_valid & i_ready;

  // Next-state and next-data selection for the occupancy machine.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case (r_state)
      OCC_EMPTY: begin
        if (i_push) begin
          w_state_nxt = OCC_ONE;
          w_head_nxt  = i_data;
        end else begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (i_push && w_pop) begin
          w_state_nxt = OCC_ONE;
          w_head_nxt  = i_data;
        end else if (i_push) begin
          w_state_nxt = OCC_TWO;
          w_skid_nxt  = i_data;
        end else if (w_pop) begin
          w_state_nxt = OCC_EMPTY;
        end else begin
          w_state_nxt = OCC_ONE;
        end
      end
      OCC_TWO: begin
        // No push can arrive here: the top gates the FIFO pop on occupancy.
        if (w_pop) begin
          w_state_nxt = OCC_ONE;
          w_head_nxt  = r_skid;
        end else begin
          w_state_nxt = OCC_TWO;
        end
      end
      default: begin
        w_state_nxt = OCC_EMPTY;
      end
    endcase
  end

  // State, valid and data registers; reset discards all buffered words.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= OCC_EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != OCC_EMPTY);
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO into a valid/ready stream via a skid buffer.
// Optional handshake counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
`ifdef FIFO_RD_STREAM_CNT_EN
  input  logic             m_ready,
  output logic [CSIZE-1:0] m_cnt
`else
  input  logic             m_ready
`endif
);

  logic       r_live;
  logic       w_rinc;
  occ_state_e w_state;

  // Holds off the first FIFO pop until one edge after reset release.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Pop depends only on registered state and rempty, never on m_ready.
  assign w_rinc = r_live & ~rempty & occ_has_room(w_state);
  assign rinc   = w_rinc;

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .i_clk   (rclk),
    .i_rst_n (rrst_n),
    .i_push  (w_rinc),
    .i_data  (rdata),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_state (w_state)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic             w_pop;
  logic [CSIZE-1:0] r_cnt;

  assign w_pop = m_valid & m_ready;

  // Completed-handshake counter, wraps naturally at 2^CSIZE.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + {{(CSIZE-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign m_cnt = r_cnt;
`else
  logic w_unused_csize;
  assign w_unused_csize = (CSIZE > 0);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO model feeds the DUT, a scoreboard checks the stream.
// Counter checks are compiled only with FIFO_RD_STREAM_CNT_EN.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CW-1:0] m_cnt;
`endif

  fifo_rd_stream #(
    .DSIZE (DW),
    .CSIZE (CW)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_data  (m_data),
    .m_valid (m_valid),
`ifdef FIFO_RD_STREAM_CNT_EN
    .m_ready (m_ready),
    .m_cnt   (m_cnt)
`else
    .m_ready (m_ready)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];
  int            occ;
  int            cyc;
  int            n_pops;
  int            stall_pct = 0;
  logic          prev_held;
  logic [DW-1:0] prev_data;
  logic          obs_rinc;
  logic          obs_valid;
  logic          obs_pop;
  logic [DW-1:0] obs_data;

  task automatic drive_fifo();
    logic stall;
    stall  = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
    rempty = (fifo_q.size() == 0) || stall;
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: observe at negedge, update models, drive FIFO after the posedge.
  task automatic tick();
    logic [DW-1:0] exp;
    @(negedge rclk);
    obs_rinc  = rinc;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_pop   = (m_valid === 1'b1) && (m_ready === 1'b1);
    n_checks++;
    if (rinc === 1'b1 && (rempty === 1'b1 || occ >= 2)) begin
      n_errors++;
      $display("FAIL rinc_guard: rinc=%b rempty=%b occ=%0d (required rinc=0)", rinc, rempty, occ);
    end
    if (prev_held) begin
      n_checks++;
      if (m_data !== prev_data || m_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL hold: m_data=%h m_valid=%b, required %h/1", m_data, m_valid, prev_data);
      end
    end
    if (obs_pop) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_extra: got %h, required no word", m_data);
      end else begin
        exp = sb_q.pop_front();
        if (m_data !== exp) begin
          n_errors++;
          $display("FAIL sb_data: got %h, required %h", m_data, exp);
        end
      end
      occ--;
      n_pops++;
    end
    if (rinc === 1'b1 && fifo_q.size() != 0) begin
      sb_q.push_back(fifo_q.pop_front());
      occ++;
    end
    prev_held = (m_valid === 1'b1) && (m_ready !== 1'b1);
    prev_data = m_data;
    @(posedge rclk);
    #1;
    cyc++;
    drive_fifo();
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #1;
    rrst_n = 1'b0;
    sb_q.delete();
    occ = 0; n_pops = 0; prev_held = 1'b0;
    drive_fifo();
    repeat (2) @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    fifo_q.delete();
    m_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs_rinc !== 1'b0 || obs_valid !== 1'b0 || obs_data !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_idle: rinc=%b valid=%b data=%h, required 0/0/00", obs_rinc, obs_valid, obs_data);
      end
    end
  endtask

  task automatic test_preload();
    int first_rinc = -1;
    int first_pop  = -1;
    int last_pop   = -1;
    fifo_q.delete();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(i[DW-1:0]);
    m_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (obs_rinc === 1'b1 && first_rinc < 0) first_rinc = c;
      if (obs_pop && first_pop < 0) first_pop = c;
      if (obs_pop) last_pop = c;
      if (c == 10) begin
        n_checks++;
        if (obs_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL preload_valid_drop: m_valid=%b, required 0", obs_valid);
        end
      end
    end
    n_checks++;
    if (first_rinc != 1) begin
      n_errors++;
      $display("FAIL preload_first_rinc: cycle %0d, required 1", first_rinc);
    end
    n_checks++;
    if (first_pop != 2 || last_pop != 9 || n_pops != 8) begin
      n_errors++;
      $display("FAIL preload_timing: pops %0d..%0d n=%0d, required 2..9 n=8", first_pop, last_pop, n_pops);
    end
  endtask

  task automatic test_backpressure();
    int n_rinc = 0;
    int pcyc[$];
    fifo_q.delete();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(i[DW-1:0]);
    m_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (obs_rinc === 1'b1) n_rinc++;
    end
    n_checks++;
    if (n_rinc != 2) begin
      n_errors++;
      $display("FAIL bp_rinc_count: %0d pulses, required 2", n_rinc);
    end
    n_checks++;
    if (dut.u_skid.r_state !== OCC_TWO) begin
      n_errors++;
      $display("FAIL bp_state: state=%0d, required %0d", dut.u_skid.r_state, OCC_TWO);
    end
    n_checks++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h01) begin
      n_errors++;
      $display("FAIL bp_head: valid=%b data=%h, required 1/01", obs_valid, obs_data);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && n_pops < 4; c++) begin
      tick();
      if (obs_pop) pcyc.push_back(c);
    end
    n_checks++;
    if (pcyc.size() != 4) begin
      n_errors++;
      $display("FAIL bp_drain_count: %0d words, required 4", pcyc.size());
    end else if (pcyc[3] - pcyc[0] != 3) begin
      n_errors++;
      $display("FAIL bp_drain_gap: span %0d cycles, required 3", pcyc[3] - pcyc[0]);
    end
  endtask

  task automatic test_random();
    fifo_q.delete();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(DW'($urandom));
    stall_pct = 25;
    m_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8000 && n_pops < 1000; c++) begin
      m_ready = ($urandom_range(1) == 1);
      tick();
    end
    stall_pct = 0;
    n_checks++;
    if (n_pops != 1000 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_count: %0d words, %0d pending, required 1000/0", n_pops, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    fifo_q.delete();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(i[DW-1:0]);
    m_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    n_checks++;
    if (dut.u_skid.r_state !== OCC_TWO) begin
      n_errors++;
      $display("FAIL mid_state: state=%0d, required %0d", dut.u_skid.r_state, OCC_TWO);
    end
    #2;
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || rinc !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_async: valid=%b data=%h rinc=%b, required 0/00/0", m_valid, m_data, rinc);
    end
    sb_q.delete();
    occ = 0; n_pops = 0; prev_held = 1'b0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 20 && n_pops < 2; c++) begin
      tick();
      if (obs_pop && first < 0) first = int'(obs_data);
    end
    n_checks++;
    if (first != 3 || n_pops != 2) begin
      n_errors++;
      $display("FAIL mid_new_head: first=%0d n=%0d, required 3/2", first, n_pops);
    end
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_cnt();
    fifo_q.delete();
    for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(8'h40 + i));
    m_ready = 1'b1;
    do_reset();
    n_checks++;
    if (m_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL cnt_reset: m_cnt=%0d, required 0", m_cnt);
    end
    for (int c = 0; c < 60 && n_pops < 20; c++) tick();
    n_checks++;
    if (m_cnt !== 4'd4 || n_pops != 20) begin
      n_errors++;
      $display("FAIL cnt_wrap: m_cnt=%0d pops=%0d, required 4/20", m_cnt, n_pops);
    end
  endtask
`endif

  initial begin
    rrst_n    = 1'b0;
    rempty    = 1'b1;
    rdata     = 8'h00;
    m_ready   = 1'b0;
    occ       = 0;
    cyc       = 0;
    n_pops    = 0;
    prev_held = 1'b0;
    prev_data = 8'h00;
    #3;
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || rinc !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: valid=%b data=%h rinc=%b, required 0/00/0", m_valid, m_data, rinc);
    end
    test_reset();
    test_preload();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
